// File: rtl/x_serializer.sv
// Parallel-to-serial front end feeding the machine_d detector: MSB-first bits on x with x_valid and frame_done.
// Optional even-parity trailer bit is enabled by defining XSER_PARITY_EN.
module x_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_len,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [3:0] W4 = 4'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef XSER_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [3:0]       cnt, cnt_d;
  logic             x_d, x_valid_d, busy_d, frame_done_d;
  logic [3:0]       eff_len;
  logic [WIDTH-1:0] aligned;
  logic             take;
`ifdef XSER_PARITY_EN
  logic             par, par_d;
`endif

  assign in_ready = (state == S_IDLE) || (state == S_DONE);
  assign take     = in_valid && in_ready;
  assign eff_len  = (in_len == 4'd0 || in_len > W4) ? W4 : in_len;
  // Left-align the selected bits so the next bit to send is always at the MSB.
  assign aligned  = in_data << (W4 - eff_len);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      x          <= 1'b0;
      x_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef XSER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      sreg       <= sreg_d;
      cnt        <= cnt_d;
      x          <= x_d;
      x_valid    <= x_valid_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
`ifdef XSER_PARITY_EN
      par        <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (take) state_d = S_SHIFT;
      S_SHIFT: if (!hold && cnt == 4'd0) begin
`ifdef XSER_PARITY_EN
        state_d = S_PARITY;
`else
        state_d = S_DONE;
`endif
      end
`ifdef XSER_PARITY_EN
      S_PARITY: if (!hold) state_d = S_DONE;
`endif
      S_DONE:  state_d = take ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered: this computes the values presented in the next cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    x_d          = x;
    x_valid_d    = 1'b0;
    busy_d       = busy;
    frame_done_d = 1'b0;
    sreg_d       = sreg;
    cnt_d        = cnt;
`ifdef XSER_PARITY_EN
    par_d        = par;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        x_d    = 1'b0;
        busy_d = 1'b0;
        if (take) begin
          x_d       = aligned[WIDTH-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
          sreg_d    = aligned << 1;
          cnt_d     = eff_len - 4'd1;
`ifdef XSER_PARITY_EN
          par_d     = aligned[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        if (!hold) begin
          if (cnt != 4'd0) begin
            x_d       = sreg[WIDTH-1];
            x_valid_d = 1'b1;
            sreg_d    = sreg << 1;
            cnt_d     = cnt - 4'd1;
`ifdef XSER_PARITY_EN
            par_d     = par ^ sreg[WIDTH-1];
`endif
          end else begin
`ifdef XSER_PARITY_EN
            x_d       = par;
            x_valid_d = 1'b1;
`else
            x_d          = 1'b0;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
`endif
          end
        end
      end
`ifdef XSER_PARITY_EN
      S_PARITY: begin
        if (!hold) begin
          x_d          = 1'b0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_x_serializer.sv
// Scoreboard bench for x_serializer: expected bits queued at drive time, popped as x_valid/frame_done appear.
// Expectations follow the XSER_PARITY_EN setting of the build.
module tb_x_serializer;

  localparam int WIDTH = 8;
`ifdef XSER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [3:0]       in_len = '0;
  logic             hold = 1'b0;
  logic             x, x_valid, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic is_end;
    logic b;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  x_serializer #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .hold       (hold),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [7:0] data, input int idx);
    logic [7:0] tmp;
    tmp = data >> idx;
    return tmp[0];
  endfunction

  task automatic push_frame(input logic [7:0] data, input int l);
    logic p;
    p = 1'b0;
    for (int i = l - 1; i >= 0; i--) begin
      sb.push_back(sb_t'{is_end: 1'b0, b: bit_of(data, i)});
      p ^= bit_of(data, i);
    end
`ifdef XSER_PARITY_EN
    sb.push_back(sb_t'{is_end: 1'b0, b: p});
`endif
    sb.push_back(sb_t'{is_end: 1'b1, b: 1'b0});
  endtask

  // Monitor: every live bit and every frame_done must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (RESET) begin
      if (x_valid) begin
        if (sb.size() == 0) check("x_valid_extra", x_valid, 1'b0);
        else begin
          mon_e = sb.pop_front();
          check("bit_not_end", mon_e.is_end, 1'b0);
          check("x", x, mon_e.b);
        end
      end
      if (frame_done) begin
        if (sb.size() == 0) check("frame_done_extra", frame_done, 1'b0);
        else begin
          mon_e = sb.pop_front();
          check("end_marker", mon_e.is_end, 1'b1);
        end
      end
    end
  end

  task automatic run_frame(input logic [7:0] data, input logic [3:0] len,
                           input int hold_at, input int hold_n);
    int l, n, fd, span;
    l    = (len == 4'd0 || len > 4'(WIDTH)) ? WIDTH : int'(len);
    span = l + PAR + hold_n;
    push_frame(data, l);
    @(posedge CLK); #1;
    in_data  = data;
    in_len   = len;
    in_valid = 1'b1;
    check("ready_before", in_ready, 1'b1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n  = 0;
    fd = 0;
    while (fd == 0 && n < 60) begin
      @(negedge CLK);
      n++;
      if (frame_done) fd = n;
      else begin
        check("busy", busy, 1'b1);
        check("ready_low", in_ready, 1'b0);
      end
      if (hold_n > 0 && n > hold_at && n <= hold_at + hold_n) begin
        check("hold_xv", x_valid, 1'b0);
        check("hold_x", x, bit_of(data, l - hold_at));
      end
      if (hold_n > 0 && n == hold_at) hold = 1'b1;
      if (hold_n > 0 && n == hold_at + hold_n) hold = 1'b0;
    end
    check("done_cycle", fd, span + 1);
    check("done_busy", busy, 1'b0);
    check("done_ready", in_ready, 1'b1);
    @(negedge CLK);
    check("done_pulse", frame_done, 1'b0);
  endtask

  task automatic back_to_back();
    int n, fd1, fd2;
    push_frame(8'h0F, 8);
    push_frame(8'h81, 8);
    @(posedge CLK); #1;
    in_data  = 8'h0F;
    in_len   = 4'd8;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_data  = 8'h81;
    n   = 0;
    fd1 = 0;
    fd2 = 0;
    while (fd2 == 0 && n < 80) begin
      @(negedge CLK);
      n++;
      if (fd1 != 0 && n == fd1 + 1) begin
        check("b2b_first_bit", x_valid, 1'b1);
        in_valid = 1'b0;
      end
      if (frame_done) begin
        if (fd1 == 0) fd1 = n;
        else fd2 = n;
      end
    end
    check("b2b_done1", fd1, 9 + PAR);
    check("b2b_done2", fd2, 2 * (9 + PAR));
    @(negedge CLK);
  endtask

  task automatic reset_mid_frame();
    int n;
    push_frame(8'hF0, 8);
    @(posedge CLK); #1;
    in_data  = 8'hF0;
    in_len   = 4'd8;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 4) begin
      @(negedge CLK);
      n++;
    end
    #2 RESET = 1'b0;
    #1;
    check("mid_rst_x", x, 1'b0);
    check("mid_rst_xv", x_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", frame_done, 1'b0);
    sb.delete();
    repeat (2) begin
      @(negedge CLK);
      check("mid_rst_no_done", frame_done, 1'b0);
    end
    #2 RESET = 1'b1;
    #1 check("mid_rst_ready", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_x", x, 1'b0);
    check("rst_xv", x_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    #2 RESET = 1'b1;
    #1 check("rst_ready", in_ready, 1'b1);

    run_frame(8'hA5, 4'd8, 0, 0);
    run_frame(8'hFF, 4'd3, 0, 0);
    run_frame(8'hFF, 4'd0, 0, 0);
    run_frame(8'hFF, 4'd12, 0, 0);
    run_frame(8'hC3, 4'd8, 2, 2);
    back_to_back();
    reset_mid_frame();
    run_frame(8'h3C, 4'd8, 0, 0);
    run_frame(8'h07, 4'd8, 0, 0);
    run_frame(8'h5A, 4'd5, 3, 1);

    repeat (3) @(negedge CLK);
    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
